op_unit_arbiter: RTL and testbench
==================================

Name: op_unit_arbiter

Overview:
- Shares one multi-cycle 32-bit operator unit (compare/add/sub/logic) among NUM_REQ requesters.
- Round-robin grant; issues the winning request to the unit; waits for completion; returns the result to the owner.
- Sits between V#-generated FSM clients and the shared operator datapath, replacing per-FSM private operators.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 32, operand/result width
- OPC_W, 3, opcode width
- TIMEOUT_CYCLES, 64, watchdog limit; used only with the optional feature

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  synchronous, active-high
- req_valid  input  NUM_REQ  per-requester request
- req_ready  output  NUM_REQ  one-hot accept pulse
- req_op  input  NUM_REQ*OPC_W  packed opcodes, requester i at [i*OPC_W +: OPC_W]
- req_a  input  NUM_REQ*DATA_W  packed operand A
- req_b  input  NUM_REQ*DATA_W  packed operand B
- resp_valid  output  NUM_REQ  one-hot response pulse
- resp_data  output  DATA_W  result, shared bus, valid with resp_valid
- resp_err  output  1  timeout flag, valid with resp_valid
- op_start  output  1  one-cycle start pulse to the unit
- op_code  output  OPC_W  latched opcode
- op_a  output  DATA_W  latched operand A
- op_b  output  DATA_W  latched operand B
- op_done  input  1  unit completion pulse
- op_result  input  DATA_W  unit result, valid with op_done

Behaviour:
- Clock and reset: one clock `clk`. `reset` is synchronous and active-high.
- Reset values: every output is 0. fsmState=IDLE. rr_ptr=0.
- Reset mid-operation: return to IDLE the next edge. The in-flight request is dropped; no resp_valid is issued for it. A late op_done is ignored.
- IDLE:
  - If any req_valid is set, pick the first set bit searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - Pulse req_ready[g] for 1 cycle.
  - Latch op, a and b from requester g into op_code/op_a/op_b. Store g.
  - Go to ISSUE.
- ISSUE: op_start=1 for exactly 1 cycle, then go to WAIT.
- WAIT: hold op_code/op_a/op_b stable.
  - On op_done: latch op_result into resp_data and go to RESPOND.
  - An op_done seen in ISSUE (same cycle as op_start) is illegal; ignore it.
- RESPOND:
  - resp_valid[g]=1 for 1 cycle.
  - rr_ptr <= (g+1) mod NUM_REQ.
  - Go to IDLE.
- Minimum latency: grant to response = 3 cycles plus unit latency. With a 1-cycle unit (op_done the cycle after op_start), a request accepted in cycle 0 gets resp_valid in cycle 4.
- Handshake rules:
  - A requester holds req_valid and operands until it sees req_ready. It may drop req_valid afterwards.
  - req_valid asserted while another request is in flight waits. No queueing beyond the inputs.
  - At most one outstanding operation at a time.
- Fairness:
  - rr_ptr advances only on completion.
  - A continuously requesting port is served at least once every NUM_REQ grants.
  - Simultaneous requests resolve purely by rotation.
- Widths: resp_data is the unit result passed through unmodified. No arithmetic is done in the arbiter. The g index is $clog2(NUM_REQ) bits.
- resp_data holds its last value between responses.
- resp_err is 0 when the macro is absent.

Optional Feature:
- Macro: OP_UNIT_ARBITER_TIMEOUT_EN.
- Defined:
  - A counter clears on entering WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without op_done, go to RESPOND with resp_data=0 and resp_err=1.
  - A stray op_done arriving later in IDLE is ignored.
- Undefined: no counter. WAIT persists indefinitely. resp_err is tied to 0.

Decomposition:
- Package op_arb_pkg holds:
  - state enum: IDLE=0, ISSUE=1, WAIT=2, RESPOND=3, in an 8-bit fsmState
  - opcode constants: OPC_EQ=0, OPC_ADD=1, OPC_SUB=2, OPC_AND=3, OPC_OR=4, OPC_XOR=5
  - defaults for DATA_W and OPC_W
- Sub-module rr_picker (combinational):
  - inputs: req vector, rr_ptr
  - outputs: any_req, grant index g
  - parameterised by NUM_REQ

Test Plan:
- Single request: req_valid=0001, op=ADD, a=5, b=7, unit responds with 12 one cycle after op_start -> req_ready=0001; op_start 1 cycle after grant; resp_valid=0001 with resp_data=0x0000000C; 4 cycles total.
- All four requesting continuously, rr_ptr=0 -> grants in order 0,1,2,3,0. No port is granted twice before the others.
- Requester 2 raises req_valid while requester 1 is in WAIT -> requester 2 is granted in the first IDLE cycle after requester 1's RESPOND.
- EQ op with a=0, b=1 -> unit result 0; resp_data=0. Then EQ with a=b=0xDEADBEEF -> resp_data=1.
- Reset asserted in WAIT with op_done one cycle later -> all outputs 0; no resp_valid; next request is granted from rr_ptr=0.
- With OP_UNIT_ARBITER_TIMEOUT_EN, TIMEOUT_CYCLES=8, unit never responds -> resp_valid after 8 WAIT cycles with resp_err=1 and resp_data=0. Without the macro -> no response after 100 cycles.

Source files
------------

// File: rtl/op_arb_pkg.sv
// op_arb_pkg: shared types and constants for the operator-unit arbiter
package op_arb_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int OPC_W_DEF = 3;
  typedef enum logic [7:0] {
    IDLE    = 8'd0,
    ISSUE   = 8'd1,
    WAIT    = 8'd2,
    RESPOND = 8'd3
  } state_t;
  localparam logic [2:0] OPC_EQ  = 3'd0;
  localparam logic [2:0] OPC_ADD = 3'd1;
  localparam logic [2:0] OPC_SUB = 3'd2;
  localparam logic [2:0] OPC_AND = 3'd3;
  localparam logic [2:0] OPC_OR  = 3'd4;
  localparam logic [2:0] OPC_XOR = 3'd5;
endpackage

// File: rtl/op_unit_arbiter_rr_picker.sv
// rr_picker: finds the first active request at or after rr_ptr, wrapping modulo NUM_REQ
module rr_picker #(
  parameter int NUM_REQ = 4,
  localparam int GW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GW-1:0]      rr_ptr,
  output logic               any_req,
  output logic [GW-1:0]      g
);
  logic [GW-1:0] idx;
  always_comb begin
    any_req = |req;
    g = rr_ptr;
    idx = '0;
    // Scan farthest offset first so the nearest active request wins last.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = GW'((int'(rr_ptr) + i) % NUM_REQ);
      if (req[idx]) g = idx;
    end
  end
endmodule

// File: rtl/op_unit_arbiter.sv
// op_unit_arbiter: round-robin sharing of one multi-cycle operator unit among NUM_REQ clients.
// Define OP_UNIT_ARBITER_TIMEOUT_EN to add a WAIT watchdog answering with resp_err after TIMEOUT_CYCLES.
module op_unit_arbiter
  import op_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int OPC_W          = OPC_W_DEF,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*OPC_W-1:0]  req_op,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]         resp_data,
  output logic                      resp_err,
  output logic                      op_start,
  output logic [OPC_W-1:0]          op_code,
  output logic [DATA_W-1:0]         op_a,
  output logic [DATA_W-1:0]         op_b,
  input  logic                      op_done,
  input  logic [DATA_W-1:0]         op_result
);
  localparam int GW = $clog2(NUM_REQ);
  state_t state_q, state_d;
  logic [GW-1:0] rr_ptr_q, rr_ptr_d, g_q, g_d, g;
  logic any_req, timeout;
  logic [OPC_W-1:0] op_code_q, op_code_d;
  logic [DATA_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d, resp_data_q, resp_data_d;
  logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
  logic resp_err_q, resp_err_d;
  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req(req_valid), .rr_ptr(rr_ptr_q), .any_req(any_req), .g(g)
  );
`ifdef OP_UNIT_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  always_comb begin
    wait_cnt_d = state_q == WAIT ? wait_cnt_q + 1'b1 : '0;
    timeout = state_q == WAIT && wait_cnt_q == CW'(TIMEOUT_CYCLES - 1);
  end
  always_ff @(posedge clk) wait_cnt_q <= reset ? '0 : wait_cnt_d;
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    rr_ptr_d = rr_ptr_q;
    g_d = g_q;
    op_code_d = op_code_q;
    op_a_d = op_a_q;
    op_b_d = op_b_q;
    resp_data_d = resp_data_q;
    resp_err_d = resp_err_q;
    resp_valid_d = '0;
    req_ready = '0;
    case (state_q)
      IDLE: if (any_req) begin
        req_ready[g] = 1'b1;
        g_d = g;
        op_code_d = req_op[int'(g)*OPC_W +: OPC_W];
        op_a_d = req_a[int'(g)*DATA_W +: DATA_W];
        op_b_d = req_b[int'(g)*DATA_W +: DATA_W];
        state_d = ISSUE;
      end
      ISSUE: state_d = WAIT;
      WAIT: if (op_done || timeout) begin
        resp_data_d = op_done ? op_result : '0;
        resp_err_d = !op_done;
        state_d = RESPOND;
      end
      RESPOND: begin
        resp_valid_d[g_q] = 1'b1;
        rr_ptr_d = int'(g_q) == NUM_REQ - 1 ? '0 : g_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rr_ptr_q <= '0;
      g_q <= '0;
      op_code_q <= '0;
      op_a_q <= '0;
      op_b_q <= '0;
      resp_data_q <= '0;
      resp_err_q <= 1'b0;
      resp_valid_q <= '0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      g_q <= g_d;
      op_code_q <= op_code_d;
      op_a_q <= op_a_d;
      op_b_q <= op_b_d;
      resp_data_q <= resp_data_d;
      resp_err_q <= resp_err_d;
      resp_valid_q <= resp_valid_d;
    end
  end
  assign op_start = state_q == ISSUE;
  assign op_code = op_code_q;
  assign op_a = op_a_q;
  assign op_b = op_b_q;
  assign resp_data = resp_data_q;
  assign resp_err = resp_err_q;
  assign resp_valid = resp_valid_q;
endmodule

// File: tb/tb_op_unit_arbiter.sv
// tb_op_unit_arbiter: scoreboard bench for op_unit_arbiter with a behavioural operator unit
module tb_op_unit_arbiter;
  import op_arb_pkg::*;
  localparam int N = 4, DW = 32, OW = 3, TO = 8;
  logic clk = 1'b0, reset = 1'b1;
  logic [N-1:0] req_valid = '0, req_ready, resp_valid;
  logic [N*OW-1:0] req_op;
  logic [N*DW-1:0] req_a, req_b;
  logic [DW-1:0] resp_data, op_a, op_b, op_result;
  logic [OW-1:0] op_code;
  logic resp_err, op_start, op_done;
  logic [OW-1:0] op_v [N];
  logic [DW-1:0] a_v [N], b_v [N];
  int hold_cnt [N];
  typedef struct { int port; logic [DW-1:0] data; } exp_t;
  typedef struct { logic [N-1:0] vec; logic [DW-1:0] data; logic err; int cyc; } obs_t;
  typedef struct { int port; int cyc; } grant_t;
  exp_t exp_q[$];
  obs_t obs_q[$];
  grant_t grant_q[$];
  int start_q[$];
  int cyc, n_cmp, n_fail;
  bit unit_en = 1'b1;
  int unit_lat = 1, stray_req, stray_seen, u_pend;
  logic [DW-1:0] u_res;
  for (genvar i = 0; i < N; i++) begin : g_pack
    assign req_op[i*OW +: OW] = op_v[i];
    assign req_a[i*DW +: DW] = a_v[i];
    assign req_b[i*DW +: DW] = b_v[i];
  end
  op_unit_arbiter #(.NUM_REQ(N), .DATA_W(DW), .OPC_W(OW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid),
    .resp_data(resp_data), .resp_err(resp_err), .op_start(op_start), .op_code(op_code),
    .op_a(op_a), .op_b(op_b), .op_done(op_done), .op_result(op_result)
  );
  always #5 clk = ~clk;
  function automatic logic [DW-1:0] model(logic [OW-1:0] op, logic [DW-1:0] a, logic [DW-1:0] b);
    case (op)
      OPC_EQ:  return {{(DW-1){1'b0}}, a == b};
      OPC_ADD: return a + b;
      OPC_SUB: return a - b;
      OPC_AND: return a & b;
      OPC_OR:  return a | b;
      OPC_XOR: return a ^ b;
      default: return '0;
    endcase
  endfunction
  // Operator unit: answers unit_lat cycles after op_start; stray_req injects an unsolicited op_done.
  initial begin
    op_done = 1'b0;
    op_result = '0;
    u_pend = 0;
    forever begin
      @(posedge clk);
      #1;
      op_done = 1'b0;
      if (u_pend > 0) begin
        u_pend--;
        if (u_pend == 0) begin
          op_done = 1'b1;
          op_result = u_res;
        end
      end else if (op_start && unit_en) begin
        u_res = model(op_code, op_a, op_b);
        u_pend = unit_lat;
      end
      if (stray_req != stray_seen) begin
        stray_seen = stray_req;
        op_done = 1'b1;
        op_result = 32'hBAD0_BAD0;
      end
    end
  end
  task automatic step();
    int g = -1;
    @(negedge clk);
    cyc++;
    if (op_start) start_q.push_back(cyc);
    if (req_ready != '0) begin
      for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
      grant_q.push_back('{port: g, cyc: cyc});
      exp_q.push_back('{port: g, data: model(op_v[g], a_v[g], b_v[g])});
    end
    if (resp_valid != '0) obs_q.push_back('{vec: resp_valid, data: resp_data, err: resp_err, cyc: cyc});
    @(posedge clk);
    #1;
    if (g >= 0) begin
      if (hold_cnt[g] > 0) begin
        hold_cnt[g]--;
        op_v[g] = OW'($urandom_range(0, 5));
        a_v[g] = $urandom;
        b_v[g] = $urandom;
      end else req_valid[g] = 1'b0;
    end
  endtask
  task automatic run(int n, int max);
    for (int k = 0; k < max && obs_q.size() < n; k++) step();
  endtask
  task automatic clear_q();
    exp_q.delete();
    obs_q.delete();
    grant_q.delete();
    start_q.delete();
  endtask
  task automatic drive(int p, logic [OW-1:0] op, logic [DW-1:0] a, logic [DW-1:0] b, int hold);
    op_v[p] = op;
    a_v[p] = a;
    b_v[p] = b;
    hold_cnt[p] = hold;
    req_valid[p] = 1'b1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    clear_q();
  endtask
  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_cmp++; if ({req_ready, op_start} !== '0) begin n_fail++; $display("FAIL reset_handshake: got ready=%0h start=%0b want 0", req_ready, op_start); end
    n_cmp++; if ({op_code, op_a, op_b} !== '0) begin n_fail++; $display("FAIL reset_operands: got %0h/%0h/%0h want 0", op_code, op_a, op_b); end
    n_cmp++; if ({resp_valid, resp_data, resp_err} !== '0) begin n_fail++; $display("FAIL reset_resp: got v=%0h d=%0h e=%0b want 0", resp_valid, resp_data, resp_err); end
    @(posedge clk);
    #1;
  endtask
  task automatic test_single();
    obs_t o;
    exp_t e;
    clear_q();
    drive(0, OPC_ADD, 32'd5, 32'd7, 0);
    run(1, 20);
    n_cmp++;
    if (obs_q.size() != 1 || grant_q.size() != 1 || start_q.size() != 1) begin
      n_fail++; $display("FAIL single_counts: got resp=%0d grant=%0d start=%0d want 1/1/1", obs_q.size(), grant_q.size(), start_q.size());
    end else begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++; if (grant_q[0].port != 0) begin n_fail++; $display("FAIL single_grant: got %0d want 0", grant_q[0].port); end
      n_cmp++; if (start_q[0] != grant_q[0].cyc + 1) begin n_fail++; $display("FAIL single_start_lat: got %0d want %0d", start_q[0] - grant_q[0].cyc, 1); end
      n_cmp++; if (o.cyc != grant_q[0].cyc + 4) begin n_fail++; $display("FAIL single_resp_lat: got %0d want 4", o.cyc - grant_q[0].cyc); end
      n_cmp++; if (o.vec !== 4'b0001) begin n_fail++; $display("FAIL single_resp_valid: got %0h want 1", o.vec); end
      n_cmp++; if (o.data !== 32'h0000_000C) begin n_fail++; $display("FAIL single_resp_data: got %0h want c", o.data); end
      n_cmp++; if (o.data !== e.data) begin n_fail++; $display("FAIL single_scoreboard: got %0h want %0h", o.data, e.data); end
    end
  endtask
  task automatic test_round_robin();
    obs_t o;
    exp_t e;
    do_reset();
    for (int i = 0; i < N; i++) drive(i, OW'($urandom_range(0, 5)), $urandom, $urandom, 1);
    run(2 * N, 200);
    n_cmp++;
    if (obs_q.size() != 2 * N || grant_q.size() != 2 * N) begin
      n_fail++; $display("FAIL rr_counts: got resp=%0d grant=%0d want %0d", obs_q.size(), grant_q.size(), 2 * N);
    end else begin
      for (int k = 0; k < 2 * N; k++) begin
        o = obs_q.pop_front();
        e = exp_q.pop_front();
        n_cmp++; if (grant_q[k].port != k % N) begin n_fail++; $display("FAIL rr_order[%0d]: got %0d want %0d", k, grant_q[k].port, k % N); end
        n_cmp++; if (o.vec !== (N'(1) << e.port) || o.data !== e.data) begin n_fail++; $display("FAIL rr_resp[%0d]: got v=%0h d=%0h want v=%0h d=%0h", k, o.vec, o.data, N'(1) << e.port, e.data); end
      end
    end
  endtask
  task automatic test_back_to_back();
    obs_t o;
    exp_t e;
    clear_q();
    unit_lat = 3;
    drive(1, OPC_SUB, 32'd100, 32'd1, 0);
    for (int k = 0; k < 10 && grant_q.size() == 0; k++) step();
    step();
    drive(2, OPC_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 0);
    drive(0, OPC_OR, 32'h1200_0000, 32'h0000_0034, 0);
    run(3, 80);
    unit_lat = 1;
    n_cmp++;
    if (obs_q.size() != 3 || grant_q.size() != 3) begin
      n_fail++; $display("FAIL b2b_counts: got resp=%0d grant=%0d want 3", obs_q.size(), grant_q.size());
    end else begin
      n_cmp++; if (grant_q[0].port != 1 || grant_q[1].port != 2 || grant_q[2].port != 0) begin n_fail++; $display("FAIL b2b_order: got %0d,%0d,%0d want 1,2,0", grant_q[0].port, grant_q[1].port, grant_q[2].port); end
      n_cmp++; if (grant_q[1].cyc != obs_q[0].cyc) begin n_fail++; $display("FAIL b2b_regrant: got cycle %0d want %0d", grant_q[1].cyc, obs_q[0].cyc); end
      for (int k = 0; k < 3; k++) begin
        o = obs_q.pop_front();
        e = exp_q.pop_front();
        n_cmp++; if (o.vec !== (N'(1) << e.port) || o.data !== e.data) begin n_fail++; $display("FAIL b2b_resp[%0d]: got v=%0h d=%0h want v=%0h d=%0h", k, o.vec, o.data, N'(1) << e.port, e.data); end
      end
    end
  endtask
  task automatic test_eq();
    clear_q();
    drive(3, OPC_EQ, 32'd0, 32'd1, 0);
    run(1, 20);
    drive(3, OPC_EQ, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0);
    run(2, 20);
    n_cmp++;
    if (obs_q.size() != 2) begin
      n_fail++; $display("FAIL eq_counts: got %0d want 2", obs_q.size());
    end else begin
      n_cmp++; if (obs_q[0].data !== 32'd0 || obs_q[0].vec !== 4'b1000) begin n_fail++; $display("FAIL eq_ne: got v=%0h d=%0h want v=8 d=0", obs_q[0].vec, obs_q[0].data); end
      n_cmp++; if (obs_q[1].data !== 32'd1 || obs_q[1].vec !== 4'b1000) begin n_fail++; $display("FAIL eq_eq: got v=%0h d=%0h want v=8 d=1", obs_q[1].vec, obs_q[1].data); end
    end
  endtask
  task automatic test_reset_mid();
    clear_q();
    drive(1, OPC_XOR, 32'hAAAA_0000, 32'h0000_5555, 0);
    run(1, 20);
    clear_q();
    unit_en = 1'b0;
    drive(2, OPC_OR, 32'h1, 32'h2, 0);
    for (int k = 0; k < 10 && grant_q.size() == 0; k++) step();
    repeat (2) step();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    stray_req++;
    @(negedge clk);
    n_cmp++; if ({req_ready, op_start, op_code, op_a, op_b} !== '0) begin n_fail++; $display("FAIL midreset_op: got start=%0b code=%0h a=%0h b=%0h want 0", op_start, op_code, op_a, op_b); end
    n_cmp++; if ({resp_valid, resp_data, resp_err} !== '0) begin n_fail++; $display("FAIL midreset_resp: got v=%0h d=%0h want 0", resp_valid, resp_data); end
    @(posedge clk);
    #1;
    clear_q();
    repeat (6) step();
    n_cmp++; if (obs_q.size() != 0 || resp_data !== '0) begin n_fail++; $display("FAIL midreset_stray: got %0d resp d=%0h want 0", obs_q.size(), resp_data); end
    unit_en = 1'b1;
    clear_q();
    drive(1, OPC_ADD, 32'd10, 32'd20, 0);
    drive(3, OPC_ADD, 32'd30, 32'd40, 0);
    run(2, 40);
    n_cmp++;
    if (grant_q.size() != 2 || obs_q.size() != 2) begin
      n_fail++; $display("FAIL midreset_counts: got grant=%0d resp=%0d want 2", grant_q.size(), obs_q.size());
    end else begin
      n_cmp++; if (grant_q[0].port != 1 || grant_q[1].port != 3) begin n_fail++; $display("FAIL midreset_rrptr: got %0d,%0d want 1,3", grant_q[0].port, grant_q[1].port); end
      n_cmp++; if (obs_q[0].data !== 32'd30 || obs_q[1].data !== 32'd70) begin n_fail++; $display("FAIL midreset_data: got %0h,%0h want 1e,46", obs_q[0].data, obs_q[1].data); end
    end
  endtask
  task automatic test_timeout();
    clear_q();
    unit_en = 1'b0;
    drive(0, OPC_ADD, 32'd1, 32'd2, 0);
`ifdef OP_UNIT_ARBITER_TIMEOUT_EN
    run(1, 40);
    n_cmp++;
    if (obs_q.size() != 1 || grant_q.size() != 1) begin
      n_fail++; $display("FAIL timeout_counts: got %0d want 1", obs_q.size());
    end else begin
      n_cmp++; if (obs_q[0].cyc != grant_q[0].cyc + 3 + TO) begin n_fail++; $display("FAIL timeout_lat: got %0d want %0d", obs_q[0].cyc - grant_q[0].cyc, 3 + TO); end
      n_cmp++; if (obs_q[0].err !== 1'b1 || obs_q[0].data !== '0 || obs_q[0].vec !== 4'b0001) begin n_fail++; $display("FAIL timeout_resp: got v=%0h d=%0h e=%0b want v=1 d=0 e=1", obs_q[0].vec, obs_q[0].data, obs_q[0].err); end
    end
`else
    run(1, 100);
    n_cmp++; if (obs_q.size() != 0 || resp_err !== 1'b0) begin n_fail++; $display("FAIL notimeout_resp: got %0d resp e=%0b want 0", obs_q.size(), resp_err); end
    n_cmp++; if (op_code !== OPC_ADD || op_a !== 32'd1 || op_b !== 32'd2) begin n_fail++; $display("FAIL notimeout_hold: got %0h/%0h/%0h want 1/1/2", op_code, op_a, op_b); end
`endif
    do_reset();
    unit_en = 1'b1;
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < N; i++) begin
      op_v[i] = '0;
      a_v[i] = '0;
      b_v[i] = '0;
      hold_cnt[i] = 0;
    end
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_eq();
    test_reset_mid();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
